or2_gate: RTL and testbench

Two-input OR for board switch inputs. SW1 and SW2 are asynchronous mechanical switches. Each input is synchronised and debounced, then the two are ORed into a registered LED drive, LED0. The block sits directly behind the board switch pins and in front of the LED pin, in the single system clock domain.

---
 rtl/or2_gate.sv | 107 ++++++++++
 tb/tb_or2_gate.sv | 127 ++++++++++++
 2 files changed

// File: rtl/or2_gate.sv
`default_nettype none
// ============================================================================
// Module   : or2_gate
// Brief    : Two switch inputs, each synchronised and debounced, ORed into a
//            registered LED drive.
// Revision : 1.0 - initial release
// ============================================================================

module or2_gate_path #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign o_level = w_s;
    end else begin : g_debounce
      localparam int c_CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

      logic               r_d;
      logic [c_CNT_W-1:0] r_cnt;

      // Any return of s to the accepted level restarts the count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_d   <= 1'b0;
          r_cnt <= '0;
        end else if (w_s == r_d) begin
          r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
          r_d   <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_level = r_d;
    end
  endgenerate

endmodule

module or2_gate #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic SW1,
  input  logic SW2,
  output logic LED0
);

  logic w_d1;
  logic w_d2;

  or2_gate_path #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_path1 (
    .clk    (clk),
    .rst    (rst),
    .i_sw   (SW1),
    .o_level(w_d1)
  );

  or2_gate_path #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_path2 (
    .clk    (clk),
    .rst    (rst),
    .i_sw   (SW2),
    .o_level(w_d2)
  );

  // Registering the OR hides any skew between simultaneous acceptances.
  always_ff @(posedge clk) begin
    if (rst) begin
      LED0 <= 1'b0;
    end else begin
      LED0 <= w_d1 | w_d2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_or2_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_or2_gate
// Brief    : Directed-vector bench for or2_gate, default build and a
//            debounce-bypass build driven from the same switches.
// Revision : 1.0 - initial release
// ============================================================================

module tb_or2_gate;

  logic clk;
  logic rst;
  logic SW1;
  logic SW2;
  logic led_db;
  logic led_nodb;

  int n_checks = 0;
  int n_fail   = 0;

  or2_gate dut (
    .clk (clk),
    .rst (rst),
    .SW1 (SW1),
    .SW2 (SW2),
    .LED0(led_db)
  );

  or2_gate #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(0)
  ) dut_nodb (
    .clk (clk),
    .rst (rst),
    .SW1 (SW1),
    .SW2 (SW2),
    .LED0(led_nodb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs changed just before tick 1; the debounced build updates on tick 7,
  // the bypass build on tick 3.
  task automatic hold_check(input string tag, input logic old_v, input logic new_v);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check({tag, "_db"},   led_db,   (i >= 7) ? new_v : old_v);
      check({tag, "_nodb"}, led_nodb, (i >= 3) ? new_v : old_v);
    end
  endtask

  task automatic apply(input string tag, input logic s1, input logic s2,
                       input logic old_v, input logic new_v);
    SW1 = s1;
    SW2 = s2;
    hold_check(tag, old_v, new_v);
  endtask

  // SW1 high for len edges starting from an all-low idle state.
  task automatic pulse(input string tag, input int len);
    logic exp_db;
    logic exp_nodb;
    SW1 = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      exp_db   = (len >= 4) && (i >= 7) && (i <= 6 + len);
      exp_nodb = (i >= 3) && (i <= 2 + len);
      check({tag, "_db"},   led_db,   exp_db);
      check({tag, "_nodb"}, led_nodb, exp_nodb);
      if (i == len) SW1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    SW1 = 1'b1;
    SW2 = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_db",   led_db,   1'b0);
      check("reset_nodb", led_nodb, 1'b0);
    end
    rst = 1'b0;
    hold_check("release", 1'b0, 1'b1);

    apply("walk_00", 1'b0, 1'b0, 1'b1, 1'b0);
    apply("walk_01", 1'b0, 1'b1, 1'b0, 1'b1);
    apply("walk_10", 1'b1, 1'b0, 1'b1, 1'b1);
    apply("walk_11", 1'b1, 1'b1, 1'b1, 1'b1);
    apply("walk_00b", 1'b0, 1'b0, 1'b1, 1'b0);
    apply("walk_10b", 1'b1, 1'b0, 1'b0, 1'b1);
    apply("swap_01", 1'b0, 1'b1, 1'b1, 1'b1);
    apply("idle_00", 1'b0, 1'b0, 1'b1, 1'b0);

    pulse("pulse3", 3);
    pulse("pulse4", 4);

    apply("hold_sw1", 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_db",   led_db,   1'b0);
    check("midrst_nodb", led_nodb, 1'b0);
    rst = 1'b0;
    hold_check("after_rst", 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
